// File: rtl/buf_dma_pkg.sv
// buf_dma_pkg: shared address-width default, FSM state type and transfer
// direction encoding used by buf_dma and its output FIFO.
package buf_dma_pkg;

  localparam int unsigned BUF_DMA_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UNLOAD
  } state_t;

  typedef enum logic {
    DIR_LOAD   = 1'b0,
    DIR_UNLOAD = 1'b1
  } dir_t;

endpackage

// File: rtl/buf_dma_fifo.sv
// buf_dma_fifo: two-entry real-valued output FIFO for the unload stream.
// The head is readable combinationally; cleared entries read as 0.0.
module buf_dma_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  real        push_d,
  input  logic       pop,
  output real        head,
  output logic [1:0] count
);

  real  mem [2];
  logic wp;
  logic rp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= 0.0;
      mem[1] <= 0.0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_d;
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/buf_dma.sv
// buf_dma: buffer DMA engine, stream -> source buffer (load) and
// destination buffer -> stream (unload). Define BUF_DMA_LAST_EN to add m_last.
module buf_dma
  import buf_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = BUF_DMA_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_v,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              cmd_rdy,
  input  logic              s_valid,
  input  real               s_data,
  output logic              s_ready,
  output logic              src_v,
  output logic [ADDR_W-1:0] src_a,
  output real               src_d,
  output logic              dst_v,
  output logic [ADDR_W-1:0] dst_a,
  input  real               dst_d,
  output logic              m_valid,
  output real               m_data,
  input  logic              m_ready,
`ifdef BUF_DMA_LAST_EN
  output logic              m_last,
`endif
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   popped;
  logic              pend;
  logic [1:0]        fcount;
  logic              pop;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] addr;

  assign cmd_rdy = (state == IDLE);
  assign busy    = (state != IDLE);
  assign s_ready = (state == LOAD);
  assign addr    = base + idx[ADDR_W-1:0];
  assign dst_a   = addr;

  // Credit check: FIFO words plus reads still in flight, less this cycle's pop.
  assign m_valid = (fcount != 2'd0);
  assign pop     = m_valid & m_ready;
  assign occ     = {1'b0, fcount} + {2'b0, pend} - {2'b0, pop};
  assign dst_v   = (state == UNLOAD) && (idx < len) && (occ < 3'd2);

`ifdef BUF_DMA_LAST_EN
  assign m_last = m_valid && (popped == len - 1'b1);
`endif

  buf_dma_fifo u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (pend),
    .push_d (dst_d),
    .pop    (pop),
    .head   (m_data),
    .count  (fcount)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      base   <= '0;
      len    <= '0;
      idx    <= '0;
      popped <= '0;
      pend   <= 1'b0;
      src_v  <= 1'b0;
      src_a  <= '0;
      src_d  <= 0.0;
      done   <= 1'b0;
    end else begin
      done  <= 1'b0;
      src_v <= 1'b0;
      pend  <= dst_v;
      case (state)
        IDLE: begin
          if (cmd_v) begin
            base   <= cmd_base;
            len    <= cmd_len;
            idx    <= '0;
            popped <= '0;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else if (dir_t'(cmd_dir) == DIR_UNLOAD) begin
              state <= UNLOAD;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (s_valid) begin
            src_v <= 1'b1;
            src_a <= addr;
            src_d <= s_data;
            idx   <= idx + 1'b1;
            if (idx == len - 1'b1) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        UNLOAD: begin
          if (dst_v) begin
            idx <= idx + 1'b1;
          end
          if (pop) begin
            popped <= popped + 1'b1;
            if (popped == len - 1'b1) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buf_dma.sv
// tb_buf_dma: directed bench for buf_dma with a queue-based transfer model
// and a buffer memory model answering dst reads one cycle later.
module tb_buf_dma;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_v = 1'b0;
  logic          cmd_dir = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_len = '0;
  logic          cmd_rdy;
  logic          s_valid = 1'b0;
  real           s_data = 0.0;
  logic          s_ready;
  logic          src_v;
  logic [AW-1:0] src_a;
  real           src_d;
  logic          dst_v;
  logic [AW-1:0] dst_a;
  real           dst_d = 0.0;
  logic          m_valid;
  real           m_data;
  logic          m_ready = 1'b1;
`ifdef BUF_DMA_LAST_EN
  logic          m_last;
`endif
  logic          busy;
  logic          done;

  buf_dma #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_v    (cmd_v),
    .cmd_dir  (cmd_dir),
    .cmd_base (cmd_base),
    .cmd_len  (cmd_len),
    .cmd_rdy  (cmd_rdy),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .src_v    (src_v),
    .src_a    (src_a),
    .src_d    (src_d),
    .dst_v    (dst_v),
    .dst_a    (dst_a),
    .dst_d    (dst_d),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
`ifdef BUF_DMA_LAST_EN
    .m_last   (m_last),
`endif
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  real mem [4096];
  always @(posedge clk) if (dst_v) dst_d <= mem[dst_a];

  int  checks = 0;
  int  errors = 0;

  int  exp_sa[$];
  real exp_sd[$];
  int  exp_da[$];
  real exp_m[$];
  int  done_due = -1;
  int  iss_cnt = 0;
  int  pop_cnt = 0;
  int  acc_cyc = 0;
  logic ed;
  logic prev_stall = 1'b0;
  real  prev_data = 0.0;

  int  src_c[$];
  int  src_al[$];
  int  pop_c[$];
  real pop_d[$];
  int  done_c[$];

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_real(input string nm, input real act, input real exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0g required=%0g cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Transfer model: every src write, dst read, stream word and done pulse
  // is checked against the queues filled from the command parameters.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      ed = (cyc == done_due);
      if (done) done_c.push_back(cyc);
      if (exp_sa.size() == 0) chk_bit("src_idle", src_v, 1'b0);
      else if (src_v) begin
        src_c.push_back(cyc);
        src_al.push_back(int'(src_a));
        chk_int("src_a", int'(src_a), exp_sa.pop_front());
        chk_real("src_d", src_d, exp_sd.pop_front());
        if (exp_sa.size() == 0) ed = 1'b1;
      end
      if (prev_stall) begin
        chk_bit("hold_valid", m_valid, 1'b1);
        chk_real("hold_data", m_data, prev_data);
      end
      if (exp_m.size() == 0) chk_bit("m_idle", m_valid, 1'b0);
      else if (m_valid) begin
`ifdef BUF_DMA_LAST_EN
        chk_bit("m_last", m_last, exp_m.size() == 1);
`endif
        if (m_ready) begin
          pop_c.push_back(cyc);
          pop_d.push_back(m_data);
          chk_real("m_data", m_data, exp_m.pop_front());
          pop_cnt++;
          if (exp_m.size() == 0) done_due = cyc + 1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (exp_da.size() == 0) chk_bit("dst_idle", dst_v, 1'b0);
      else if (dst_v) begin
        chk_int("dst_a", int'(dst_a), exp_da.pop_front());
        chk_bit("fifo_room", (iss_cnt - pop_cnt) < 2, 1'b1);
        iss_cnt++;
      end
      chk_bit("done", done, ed);
    end
  end

  task automatic clear_logs();
    src_c.delete(); src_al.delete(); pop_c.delete(); pop_d.delete(); done_c.delete();
    iss_cnt = 0;
    pop_cnt = 0;
  endtask

  task automatic issue(input logic dir, input int base, input int len);
    int g = 0;
    while (!cmd_rdy && g < 100) begin @(posedge clk); #1; g++; end
    cmd_v = 1'b1; cmd_dir = dir; cmd_base = AW'(base); cmd_len = (AW+1)'(len);
    @(posedge clk); #1;
    cmd_v = 1'b0;
    acc_cyc = cyc;
    if (len == 0) done_due = cyc;
  endtask

  task automatic run_load(input int base, input int len, input real d0, input real step);
    int k = 0;
    int g = 0;
    logic fire;
    for (int i = 0; i < len; i++) begin
      exp_sa.push_back((base + i) % 4096);
      exp_sd.push_back(d0 + i * step);
    end
    issue(1'b0, base, len);
    s_valid = 1'b1; s_data = d0;
    while (k < len && g < 200) begin
      @(negedge clk); fire = s_ready;
      @(posedge clk); #1;
      g++;
      if (fire) begin
        k++;
        if (k < len) s_data = d0 + k * step; else s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk_int("ld_left", exp_sa.size(), 0);
  endtask

  task automatic run_unload(input int base, input int len, input logic toggle, input logic noise);
    int i = 0;
    for (int k = 0; k < len; k++) begin
      exp_da.push_back((base + k) % 4096);
      exp_m.push_back(mem[(base + k) % 4096]);
    end
    issue(1'b1, base, len);
    if (noise) begin s_valid = 1'b1; s_data = 99.0; end
    while (exp_m.size() != 0 && i < 200) begin
      m_ready = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      cmd_v = noise && (i == 3);
      cmd_dir = 1'b0; cmd_len = (AW+1)'(5);
      i++;
      @(posedge clk); #1;
    end
    cmd_v = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk_int("ul_left", exp_m.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) mem[10 + k] = 0.5 + k;
    for (int k = 0; k < 8; k++) mem[100 + k] = k + 0.25;
    for (int k = 0; k < 5; k++) mem[200 + k] = 20.0 + k;

    repeat (2) @(negedge clk);
    chk_bit("rst_cmd_rdy", cmd_rdy, 1'b1);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_s_ready", s_ready, 1'b0);
    chk_bit("rst_src_v", src_v, 1'b0);
    chk_bit("rst_dst_v", dst_v, 1'b0);
    chk_bit("rst_m_valid", m_valid, 1'b0);
    chk_int("rst_src_a", int'(src_a), 0);
    chk_int("rst_dst_a", int'(dst_a), 0);
    chk_real("rst_src_d", src_d, 0.0);
    chk_real("rst_m_data", m_data, 0.0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;

    // Load base 0, len 4, data 1.0..4.0 back to back.
    clear_logs();
    run_load(0, 4, 1.0, 1.0);
    chk_int("ld_n", src_c.size(), 4);
    chk_int("ld_first_cyc", src_c[0], acc_cyc + 1);
    chk_int("ld_last_cyc", src_c[3], acc_cyc + 4);
    chk_int("ld_last_a", src_al[3], 3);
    chk_int("ld_done_cyc", done_c[0], acc_cyc + 4);

    // Load across the top of the buffer.
    clear_logs();
    run_load(4094, 4, 10.0, 1.0);
    chk_int("wrap_a1", src_al[1], 4095);
    chk_int("wrap_a2", src_al[2], 0);
    chk_int("wrap_a3", src_al[3], 1);

    // Unload base 10, len 3 with m_ready held high.
    clear_logs();
    run_unload(10, 3, 1'b0, 1'b0);
    chk_int("ul_n", pop_c.size(), 3);
    chk_int("ul_first_cyc", pop_c[0], acc_cyc + 2);
    chk_int("ul_last_cyc", pop_c[2], acc_cyc + 4);
    chk_real("ul_d2", pop_d[2], 2.5);
    chk_int("ul_done_cyc", done_c[0], acc_cyc + 5);

    // Unload len 8 under 1,0,0,1 backpressure, with a stray command and
    // s_valid held during the transfer.
    clear_logs();
    run_unload(100, 8, 1'b1, 1'b1);
    chk_int("bp_n", pop_d.size(), 8);
    chk_real("bp_d7", pop_d[7], 7.25);
    chk_int("bp_done_n", done_c.size(), 1);

    // Zero-length commands in both directions.
    clear_logs();
    issue(1'b0, 50, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk_int("len0_ld_done", done_c[0], acc_cyc);
    chk_bit("len0_ld_busy", busy, 1'b0);
    clear_logs();
    issue(1'b1, 60, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk_int("len0_ul_done", done_c[0], acc_cyc);
    chk_int("len0_ul_n", done_c.size(), 1);

    // Reset after two of five unload words, then a single-word load.
    clear_logs();
    for (int k = 0; k < 5; k++) begin
      exp_da.push_back(200 + k);
      exp_m.push_back(mem[200 + k]);
    end
    issue(1'b1, 200, 5);
    for (int g = 0; g < 40 && pop_cnt < 2; g++) begin @(posedge clk); #1; end
    chk_int("mid_pops", pop_cnt, 2);
    reset = 1'b1;
    @(negedge clk);
    chk_bit("mid_m_valid", m_valid, 1'b0);
    chk_bit("mid_cmd_rdy", cmd_rdy, 1'b1);
    chk_bit("mid_busy", busy, 1'b0);
    chk_bit("mid_dst_v", dst_v, 1'b0);
    exp_da.delete(); exp_m.delete(); exp_sa.delete(); exp_sd.delete();
    prev_stall = 1'b0;
    done_due = -1;
    clear_logs();
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    run_load(7, 1, 9.0, 0.0);
    chk_int("post_n", src_al.size(), 1);
    chk_int("post_a", src_al[0], 7);
    chk_int("post_done", done_c[0], acc_cyc + 1);

    repeat (2) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buf_dma.md
BUF_DMA -- requirements
Module: buf_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving buffer address width (depth 2**ADDR_W = 4096 words).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_v  input  1  command valid.
REQ-005 SHALL have port cmd_dir  input  1  0 = load (stream to source buffer), 1 = unload (destination buffer to stream).
REQ-006 SHALL have port cmd_base  input  ADDR_W  first buffer address.
REQ-007 SHALL have port cmd_len  input  ADDR_W+1  word count, 0..4096.
REQ-008 SHALL have port cmd_rdy  output  1  command accepted when cmd_v & cmd_rdy.
REQ-009 SHALL have ports s_valid input 1, s_data input real, s_ready output 1  load input stream.
REQ-010 SHALL have ports src_v output 1, src_a output ADDR_W, src_d output real  source buffer write port.
REQ-011 SHALL have ports dst_v output 1, dst_a output ADDR_W, dst_d input real  destination buffer read port; dst_d is valid the cycle after dst_v.
REQ-012 SHALL have ports m_valid output 1, m_data output real, m_ready input 1  unload output stream.
REQ-013 SHALL have ports busy output 1 (state not IDLE) and done output 1 (one-cycle completion pulse).

Function
REQ-014 SHALL implement FSM IDLE, LOAD, UNLOAD; cmd_rdy = 1 only in IDLE; handshake latches base, len, dir and clears index.
REQ-015 SHALL, on a command with cmd_len = 0, stay in IDLE, transfer nothing, and pulse done the next cycle.
REQ-016 SHALL, in LOAD, drive s_ready = 1; each s_valid & s_ready beat registers src_v = 1, src_a = base+idx, src_d = s_data on the next cycle, then idx increments.
REQ-017 SHALL compute every address as (base+idx) mod 2**ADDR_W, wrapping 4095 to 0.
REQ-018 SHALL, in LOAD, return to IDLE and pulse done in the cycle src_v carries the final word; s_ready = 0 from that cycle.
REQ-019 SHALL, in UNLOAD, assert dst_v with dst_a = base+idx for one cycle per word while issued < len and (fifo_count + inflight - pop) < 2.
REQ-020 SHALL capture dst_d into a 2-entry output FIFO the cycle after each dst_v; m_valid = FIFO not empty; m_data = FIFO head; pop on m_valid & m_ready.
REQ-021 SHALL sustain one word per cycle when m_ready is held high; first m_valid two cycles after command accept.
REQ-022 SHALL hold m_data stable while m_valid & !m_ready; no word dropped or duplicated under any m_ready pattern.
REQ-023 SHALL, in UNLOAD, return to IDLE and pulse done the cycle after the final word pops.
REQ-024 SHALL ignore cmd_v while busy; s_valid outside LOAD is not consumed.

Reset
REQ-025 SHALL, on reset (including mid-transfer), force IDLE, clear FIFO, index and inflight; outputs: cmd_rdy 1, all other 1-bit outputs 0, src_a/dst_a 0, src_d/m_data 0.0.

Configuration
REQ-026 SHALL, with BUF_DMA_LAST_EN defined, add output m_last (1 bit) asserted with the final unload word only; without it, port m_last is absent and behaviour is otherwise identical.

Structure
REQ-027 SHALL place ADDR_W default, the FSM state enum and the direction encoding in shared package buf_dma_pkg.
REQ-028 SHALL implement the output FIFO as sub-module buf_dma_fifo (2 entries, real data, push/pop/count).

Verification
REQ-029 SHALL cover load base 0, len 4, s_data 1.0..4.0 back-to-back -> src writes a=0..3 d=1.0..4.0 on consecutive cycles, done after 4th.
REQ-030 SHALL cover load base 4094, len 4 -> src_a 4094, 4095, 0, 1.
REQ-031 SHALL cover unload base 10, len 3, m_ready = 1, buffer 10..12 = 0.5, 1.5, 2.5 -> m_data 0.5, 1.5, 2.5 on 3 consecutive cycles, done next cycle.
REQ-032 SHALL cover unload len 8 with m_ready toggling 1,0,0,1 pattern -> all 8 words in order, at most 2 outstanding, never a dst_v with no FIFO room.
REQ-033 SHALL cover reset asserted mid-unload after 2 of 5 words -> IDLE next edge, m_valid 0, cmd_rdy 1; new load len 1 then completes normally.
REQ-034 SHALL cover cmd_len 0 -> no src_v/dst_v, done one cycle after accept.
